pulse_mode_classifier: RTL and testbench
========================================

// Module: pulse_mode_classifier
// PURPOSE
//  Multi-channel successor to the single-input AUX pulse-width mode detector. Each channel
//  syncs an async pulse input and samples its level SAMPLE_POINT cycles after each rising edge
//  (high = long pulse = mode 1, low = short pulse = mode 0). A mode is declared only after
//  CONFIRM consecutive identical samples. Adds per-channel valid/change flags and loss-of-signal
//  timeout. Drives LED / relay mode logic downstream.
// PARAMETERS
//  CHANNELS      2       number of independent input channels
//  CNT_W         26      width of per-channel cycle counters (must hold TIMEOUT)
//  SAMPLE_POINT  75000   cycles from detected rising edge to level sample (>=1, <TIMEOUT)
//  CONFIRM       5       consecutive matching samples needed to declare a mode (>=1, <=15)
//  TIMEOUT       1000000 cycles without a rising edge before channel is declared lost
//  SYNC_STAGES   2       input synchroniser depth (>=2)
// PORTS
//  CLOCK_50     in   1         system clock, all logic on posedge
//  RESET_N      in   1         asynchronous active-low reset
//  AUX_INPUT    in   CHANNELS  async pulse inputs, bit i = channel i
//  MODE         out  CHANNELS  confirmed mode per channel (1 = long pulse, 0 = short)
//  MODE_VALID   out  CHANNELS  1 = MODE[i] confirmed and signal present
//  MODE_CHANGE  out  CHANNELS  1-cycle strobe when MODE[i] newly confirmed or changed
//  SAMPLE_TICK  out  CHANNELS  1-cycle strobe in the cycle channel i takes its sample
// BEHAVIOUR
//  - Reset (RESET_N=0, async): all sync flops, counters, streaks = 0; every channel in IDLE;
//    MODE, MODE_VALID, MODE_CHANGE, SAMPLE_TICK = 0. Channels fully independent afterwards.
//  - Sync: SYNC_STAGES flops per bit, then one "prev" flop; rise = sync & ~prev. Prev resets to
//    0, so an input already high when reset releases counts as a rising edge.
//  - Per-channel FSM:
//    IDLE:     on rise -> MEASURE, cnt=1.
//    MEASURE:  cnt++ each cycle; rises ignored. When cnt==SAMPLE_POINT: s = sync level,
//              SAMPLE_TICK=1 that cycle; -> WAIT_LOW if s=1, else -> IDLE.
//    WAIT_LOW: stay until sync==0 -> IDLE (skips remainder of the long pulse).
//  - Confirmation (evaluated on the sample cycle, results registered, visible next cycle):
//    if streak==0 or s!=cand: cand=s, streak=1; else streak=min(streak+1,CONFIRM).
//    When streak (new value) == CONFIRM and (!MODE_VALID or MODE!=cand):
//    MODE=cand, MODE_VALID=1, MODE_CHANGE=1 for one cycle.
//    Matching samples after confirmation: no strobe. A single mismatch restarts the streak;
//    MODE/MODE_VALID are held until the new value is itself confirmed.
//    CONFIRM=1: every sample differing from MODE (or first sample) changes MODE immediately.
//  - Latency: rise seen 1 cycle after the sync-chain output goes high; sample SAMPLE_POINT
//    cycles after rise; MODE/MODE_CHANGE update 1 cycle after SAMPLE_TICK.
//  - Timeout: per-channel lost counter cleared on each rise, else increments (saturating).
//    On reaching TIMEOUT: MODE_VALID=0, MODE=0, streak=0, FSM -> IDLE (covers stuck high in
//    WAIT_LOW or stuck low). No MODE_CHANGE strobe on timeout. A rise in the same cycle wins
//    (counter clears, no timeout).
//  - All counters CNT_W bits, unsigned, never wrap (saturate or are cleared before overflow).
// TESTING (bench params: CHANNELS=2, SAMPLE_POINT=10, CONFIRM=3, TIMEOUT=100)
//  1 ch0: 4 pulses, 20 cyc high, 50 cyc period -> SAMPLE_TICK x4, MODE[0]=1, MODE_VALID[0]=1
//    and one MODE_CHANGE[0] after 3rd sample; ch1 outputs stay 0.
//  2 ch0: 3 pulses 5 cyc high -> MODE[0]=0, VALID=1, one strobe; then 2 long + 1 short ->
//    no change; then 3 long -> MODE[0]=1 with one strobe.
//  3 ch0 long pulses, ch1 short pulses interleaved -> MODE=2'b01, VALID=2'b11, independent.
//  4 after confirmation hold ch0 low 100 cyc -> VALID[0]=0, MODE[0]=0, no strobe; resumed
//    pulses re-confirm after 3 samples. Repeat with input stuck high: same result.
//  5 RESET_N low mid-MEASURE and after confirmation -> all outputs 0 immediately
//    (async); input held high through release is treated as a rising edge.
//  6 glitch: a 1-cycle high pulse shorter than sync -> at most one short sample, no mode
//    change while a confirmed long mode exists.

Source files
------------

// File: rtl/pulse_mode_classifier.sv
// rtl/pulse_mode_classifier.sv - multi-channel pulse-width mode classifier with confirmation and loss-of-signal timeout
//
// Ports:
//   CLOCK_50     in   1         system clock, all logic on posedge
//   RESET_N      in   1         asynchronous active-low reset
//   AUX_INPUT    in   CHANNELS  async pulse inputs, bit i = channel i
//   MODE         out  CHANNELS  confirmed mode per channel (1 = long pulse, 0 = short)
//   MODE_VALID   out  CHANNELS  MODE[i] confirmed and signal present
//   MODE_CHANGE  out  CHANNELS  1-cycle strobe when MODE[i] newly confirmed or changed
//   SAMPLE_TICK  out  CHANNELS  1-cycle strobe in the cycle channel i samples its level

module pulse_mode_classifier #(
    parameter int CHANNELS     = 2,
    parameter int CNT_W        = 26,
    parameter int SAMPLE_POINT = 75000,
    parameter int CONFIRM      = 5,
    parameter int TIMEOUT      = 1000000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [CHANNELS-1:0] AUX_INPUT,
    output logic [CHANNELS-1:0] MODE,
    output logic [CHANNELS-1:0] MODE_VALID,
    output logic [CHANNELS-1:0] MODE_CHANGE,
    output logic [CHANNELS-1:0] SAMPLE_TICK
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEASURE  = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SAMPLE_CNT  = CNT_W'(SAMPLE_POINT);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [3:0]       CONFIRM_CNT = 4'(CONFIRM);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   prev_q, prev_d;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic [CNT_W-1:0]       lost_q, lost_d;
        logic                   cand_q, cand_d;
        logic [3:0]             streak_q, streak_d;
        logic                   mode_q, mode_d;
        logic                   valid_q, valid_d;
        logic                   change_q, change_d;

        logic                   level;
        logic                   rise;
        logic                   sample;
        logic                   timeout;
        logic                   cand_new;
        logic [3:0]             streak_new;

        always_comb begin
            // Synchroniser shifts towards the MSB; the MSB is the usable level.
            sync_d = {sync_q[SYNC_STAGES-2:0], AUX_INPUT[g]};
            level  = sync_q[SYNC_STAGES-1];
            prev_d = level;
            rise   = level & ~prev_q;
            sample = (state_q == ST_MEASURE) && (cnt_q == SAMPLE_CNT);

            // Lost counter saturates at TIMEOUT; the timeout condition then stays
            // asserted, pinning the channel in IDLE until the next rise.
            if (rise) begin
                lost_d = '0;
            end else if (lost_q == TIMEOUT_CNT) begin
                lost_d = lost_q;
            end else begin
                lost_d = lost_q + CNT_W'(1);
            end
            timeout = !rise && (lost_d == TIMEOUT_CNT);

            // Candidate/streak update as it would apply if this is the sample cycle.
            if ((streak_q == 4'd0) || (level != cand_q)) begin
                cand_new   = level;
                streak_new = 4'd1;
            end else begin
                cand_new   = cand_q;
                streak_new = (streak_q >= CONFIRM_CNT) ? CONFIRM_CNT : streak_q + 4'd1;
            end

            state_d  = state_q;
            cnt_d    = cnt_q;
            cand_d   = cand_q;
            streak_d = streak_q;
            mode_d   = mode_q;
            valid_d  = valid_q;
            change_d = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_MEASURE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (sample) begin
                        cnt_d   = '0;
                        state_d = level ? ST_WAIT_LOW : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOW: begin
                    if (!level) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (sample) begin
                cand_d   = cand_new;
                streak_d = streak_new;
                if ((streak_new == CONFIRM_CNT) && (!valid_q || (mode_q != cand_new))) begin
                    mode_d   = cand_new;
                    valid_d  = 1'b1;
                    change_d = 1'b1;
                end
            end

            // Loss of signal drops the mode silently, with no change strobe.
            if (timeout) begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                streak_d = 4'd0;
                mode_d   = 1'b0;
                valid_d  = 1'b0;
                change_d = 1'b0;
            end
        end

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                sync_q   <= '0;
                prev_q   <= 1'b0;
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                lost_q   <= '0;
                cand_q   <= 1'b0;
                streak_q <= 4'd0;
                mode_q   <= 1'b0;
                valid_q  <= 1'b0;
                change_q <= 1'b0;
            end else begin
                sync_q   <= sync_d;
                prev_q   <= prev_d;
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                lost_q   <= lost_d;
                cand_q   <= cand_d;
                streak_q <= streak_d;
                mode_q   <= mode_d;
                valid_q  <= valid_d;
                change_q <= change_d;
            end
        end

        assign MODE[g]        = mode_q;
        assign MODE_VALID[g]  = valid_q;
        assign MODE_CHANGE[g] = change_q;
        // Decoded from registered state so it lines up with the sample cycle.
        assign SAMPLE_TICK[g] = sample;
    end

endmodule

// File: tb/tb_pulse_mode_classifier.sv
// tb/tb_pulse_mode_classifier.sv - directed self-checking bench for pulse_mode_classifier

module tb_pulse_mode_classifier;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] aux = 2'b00;
    logic [1:0] mode, mode_valid, mode_change, sample_tick;

    always #5 clk = ~clk;

    pulse_mode_classifier #(
        .CHANNELS    (2),
        .CNT_W       (26),
        .SAMPLE_POINT(10),
        .CONFIRM     (3),
        .TIMEOUT     (100),
        .SYNC_STAGES (2)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .AUX_INPUT  (aux),
        .MODE       (mode),
        .MODE_VALID (mode_valid),
        .MODE_CHANGE(mode_change),
        .SAMPLE_TICK(sample_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt [2];
    int chg_cnt  [2];
    int t0, t1, c0, c1;
    int lat0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            tick_cnt[i] += int'(sample_tick[i]);
            chg_cnt[i]  += int'(mode_change[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        t0 = tick_cnt[0];
        t1 = tick_cnt[1];
        c0 = chg_cnt[0];
        c1 = chg_cnt[1];
    endtask

    // One period per channel: channel i high for the first h_i cycles (0 = no pulse).
    task automatic pulse(input int h0, input int h1, input int period);
        for (int t = 0; t < period; t++) begin
            aux[0] = (t < h0);
            aux[1] = (t < h1);
            @(posedge clk);
            @(negedge clk);
            if (sample_tick[0] && lat0 < 0) lat0 = t + 1;
        end
    endtask

    task automatic idle(input int n);
        aux = 2'b00;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        lat0 = -1;
        repeat (3) @(negedge clk);
        check("reset_mode",   mode,        0);
        check("reset_valid",  mode_valid,  0);
        check("reset_change", mode_change, 0);
        check("reset_tick",   sample_tick, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: four long pulses on ch0
        snap();
        pulse(20, 0, 50);
        check("t1_latency", lat0, 12);
        pulse(20, 0, 50);
        check("t1_valid_after2", mode_valid[0], 0);
        pulse(20, 0, 50);
        check("t1_valid_after3", mode_valid[0], 1);
        pulse(20, 0, 50);
        check("t1_ticks0", tick_cnt[0] - t0, 4);
        check("t1_chg0",   chg_cnt[0] - c0, 1);
        check("t1_mode",   mode, 2'b01);
        check("t1_valid",  mode_valid, 2'b01);
        check("t1_ticks1", tick_cnt[1] - t1, 0);

        // 2: short confirm, interrupted long streak, long confirm
        snap();
        repeat (3) pulse(5, 0, 50);
        check("t2_mode_short", mode[0], 0);
        check("t2_valid",      mode_valid[0], 1);
        check("t2_chg_short",  chg_cnt[0] - c0, 1);
        snap();
        pulse(20, 0, 50);
        pulse(20, 0, 50);
        pulse(5, 0, 50);
        check("t2_mode_held", mode[0], 0);
        check("t2_chg_none",  chg_cnt[0] - c0, 0);
        snap();
        repeat (3) pulse(20, 0, 50);
        check("t2_mode_long", mode[0], 1);
        check("t2_chg_long",  chg_cnt[0] - c0, 1);

        // 3: both channels, independent modes
        snap();
        repeat (3) pulse(20, 5, 50);
        check("t3_mode",   mode, 2'b01);
        check("t3_valid",  mode_valid, 2'b11);
        check("t3_chg0",   chg_cnt[0] - c0, 0);
        check("t3_chg1",   chg_cnt[1] - c1, 1);
        check("t3_ticks0", tick_cnt[0] - t0, 3);
        check("t3_ticks1", tick_cnt[1] - t1, 3);

        // 4: loss of signal, stuck low then stuck high
        snap();
        idle(30);
        check("t4_valid_before_to", mode_valid, 2'b11);
        idle(40);
        check("t4_valid_lost", mode_valid, 2'b00);
        check("t4_mode_lost",  mode, 2'b00);
        check("t4_chg_to0",    chg_cnt[0] - c0, 0);
        check("t4_chg_to1",    chg_cnt[1] - c1, 0);
        snap();
        repeat (3) pulse(20, 0, 50);
        check("t4_reconf_valid", mode_valid[0], 1);
        check("t4_reconf_mode",  mode[0], 1);
        check("t4_reconf_chg",   chg_cnt[0] - c0, 1);
        snap();
        aux[0] = 1'b1;
        repeat (150) @(negedge clk);
        check("t4_stuck_valid", mode_valid[0], 0);
        check("t4_stuck_mode",  mode[0], 0);
        check("t4_stuck_ticks", tick_cnt[0] - t0, 1);
        check("t4_stuck_chg",   chg_cnt[0] - c0, 0);
        idle(20);
        snap();
        repeat (3) pulse(20, 0, 50);
        check("t4_stuck_reconf_valid", mode_valid[0], 1);
        check("t4_stuck_reconf_chg",   chg_cnt[0] - c0, 1);

        // 5: async reset mid-measure with a confirmed mode
        aux[0] = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_mode",   mode,        0);
        check("t5_rst_valid",  mode_valid,  0);
        check("t5_rst_change", mode_change, 0);
        check("t5_rst_tick",   sample_tick, 0);
        repeat (3) @(negedge clk);
        snap();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        idle(30);
        check("t5_rel_ticks", tick_cnt[0] - t0, 1);
        check("t5_rel_valid", mode_valid[0], 0);

        // 6: one-cycle glitch while long mode is confirmed
        repeat (3) pulse(20, 0, 50);
        check("t6_pre_mode", mode[0], 1);
        snap();
        aux[0] = 1'b1;
        @(negedge clk);
        idle(50);
        check("t6_glitch_ticks", tick_cnt[0] - t0, 1);
        check("t6_glitch_chg",   chg_cnt[0] - c0, 0);
        check("t6_glitch_mode",  mode[0], 1);
        check("t6_glitch_valid", mode_valid[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
